// File: rtl/fd_pkg.sv
// Shared definitions for the fetch->decode queue: RV32I opcode values and
// the immediate-format classification used by the immediate generator.
package fd_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_CALC = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_SHAMT,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_J,
    IMM_U
  } imm_type_t;

endpackage

// File: rtl/fd_imm_gen.sv
// Combinational immediate generator: classifies the opcode into an immediate
// format and assembles the XLEN-wide immediate. When FD_ILLEGAL_CHK_EN is
// defined it also reports whether the opcode belongs to the supported set.
module fd_imm_gen
  import fd_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
`ifdef FD_ILLEGAL_CHK_EN
  output logic            known,
`endif
  output logic [XLEN-1:0] imm
);

  imm_type_t   imm_type;
  logic        opcode_known;
  logic [31:0] imm32;

  // Map the opcode (and shift funct3) to an immediate format.
  always_comb begin
    imm_type     = IMM_NONE;
    opcode_known = 1'b1;
    case (inst[6:0])
      OP_R:              imm_type = IMM_NONE;
      OP_I_CALC:         imm_type = (inst[13:12] == 2'b01) ? IMM_SHAMT : IMM_I;
      OP_JALR, OP_LOAD:  imm_type = IMM_I;
      OP_STORE:          imm_type = IMM_S;
      OP_BRANCH:         imm_type = IMM_B;
      OP_JAL:            imm_type = IMM_J;
      OP_LUI, OP_AUIPC:  imm_type = IMM_U;
      default: begin
        imm_type     = IMM_NONE;
        opcode_known = 1'b0;
      end
    endcase
  end

  // Assemble the 32-bit immediate for the selected format.
  always_comb begin
    imm32 = '0;
    case (imm_type)
      IMM_SHAMT: imm32 = {27'b0, inst[24:20]};
      IMM_I:     imm32 = {{20{inst[31]}}, inst[31:20]};
      IMM_S:     imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:     imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_J:     imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      IMM_U:     imm32 = {inst[31:12], 12'b0};
      default:   imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

`ifdef FD_ILLEGAL_CHK_EN
  assign known = opcode_known & (inst[1:0] == 2'b11);
`else
  logic unused_known;
  assign unused_known = opcode_known;
`endif

endmodule

// File: rtl/fd_pipe_queue.sv
// Fetch->decode boundary queue: DEPTH-entry FIFO of {PC, instruction} with
// valid/ready on both sides and a flush for redirects. The head entry is
// presented split into fields with its immediate already generated.
// Optional feature macro: FD_ILLEGAL_CHK_EN adds the out_illegal output.
module fd_pipe_queue
  import fd_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      inst31_25,
  output logic [4:0]      inst24_20,
  output logic [4:0]      inst19_15,
  output logic [2:0]      inst14_12,
  output logic [4:0]      inst11_7,
  output logic [6:0]      inst6_0,
`ifdef FD_ILLEGAL_CHK_EN
  output logic            out_illegal,
`endif
  output logic [XLEN-1:0] imm
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [31:0]     inst_mem [DEPTH];

  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0] count_reg,  count_next;
  logic          in_ready_reg;
  logic          push, pop;
  logic [31:0]   head_inst;

  // Handshakes use the registered ready, so there is no input->output path.
  // A flush overrides any same-cycle transfer.
  assign push = in_valid & in_ready_reg & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  // Next pointer/count values; flush returns everything to empty.
  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  // Pointer, count and ready registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      in_ready_reg <= 1'b1;
    end else begin
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      count_reg    <= count_next;
      in_ready_reg <= (count_next < FULL_COUNT);
    end
  end

  // One storage slot per entry; written only by an accepted push at its index.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      // Slot gi capture register.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pc_mem[gi]   <= '0;
          inst_mem[gi] <= '0;
        end else if (push && (wr_ptr_reg == AW'(gi))) begin
          pc_mem[gi]   <= in_pc;
          inst_mem[gi] <= in_inst;
        end
      end
    end
  endgenerate

  assign in_ready  = in_ready_reg;
  assign out_valid = (count_reg != '0);
  assign head_inst = inst_mem[rd_ptr_reg];
  assign out_pc    = pc_mem[rd_ptr_reg];
  assign inst31_25 = head_inst[31:25];
  assign inst24_20 = head_inst[24:20];
  assign inst19_15 = head_inst[19:15];
  assign inst14_12 = head_inst[14:12];
  assign inst11_7  = head_inst[11:7];
  assign inst6_0   = head_inst[6:0];

`ifdef FD_ILLEGAL_CHK_EN
  logic head_known;

  fd_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst  (head_inst),
    .known (head_known),
    .imm   (imm)
  );

  assign out_illegal = out_valid & ~head_known;
`else
  fd_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst (head_inst),
    .imm  (imm)
  );
`endif

endmodule
